io_report_fifo_port: RTL
========================

Name: io_report_fifo_port

Overview:
Parametrised memory-mapped input-peripheral wrapper for the main 8-bit bus. It is the generalised successor to the fixed 4-byte mouse port. It buffers multi-byte device reports (mouse, keyboard, sensors) in a DEPTH-deep FIFO, so bursts are not lost between CPU polls. The CPU reads the head report through a register window, pops it with a bus write, and is notified through the interrupt raise/ack pair.

Parameters:
BASE_ADDR, 8'hA0, first bus address of the register window
NBYTES, 4, bytes per report (1..14)
DEPTH, 8, FIFO depth in reports (power of 2, >=2); AW = log2(DEPTH) is a localparam

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
BUS_DATA  inout  8  shared data bus; driven only during a read of this block, else 8'hZZ
BUS_ADDR  in  8  bus address
BUS_WE  in  1  1 = CPU write, 0 = read
REPORT_VALID  in  1  one-cycle strobe: REPORT_DATA holds a complete report
REPORT_DATA  in  NBYTES*8  report payload; byte k is bits [8k+7:8k]
BUS_INTERRUPT_RAISE  out  1  interrupt request to the CPU
BUS_INTERRUPT_ACK  in  1  interrupt acknowledge from the CPU

Behaviour:
- Window: BASE_ADDR .. BASE_ADDR+NBYTES+1. Hit = address inside the window; offset = BUS_ADDR - BASE_ADDR.
- Offset 0, STATUS (read-only): bit0 empty, bit1 full, bit2 overflow (sticky), bits7:3 = 0.
- Offset 1, COUNT (read): zero-extended level, 0..DEPTH. A write of any value pops the head report; a pop when empty is ignored.
- Offsets 2..NBYTES+1, HEAD byte k (read-only): byte k of the oldest report; reads 8'h00 when empty.
- A write to offset 0 with data bit7 = 1 clears overflow. All other writes are ignored.
- Read timing: output data register and drive enable are both registered. If a read hits in cycle N, BUS_DATA carries the value sampled in cycle N during cycle N+1. The drive enable falls in the cycle after the address leaves the window or BUS_WE rises.
- Push: REPORT_VALID with level < DEPTH writes the tail entry; level +1 in the next cycle.
- Full push: REPORT_VALID with level = DEPTH drops the report and sets overflow.
- Simultaneous push and pop:
  - Not empty: both happen; level unchanged; no overflow, even when full.
  - Empty: the pop is ignored and the push is accepted.
- Pointers: AW-bit read/write pointers wrap modulo DEPTH. The level is a separate AW+1-bit counter.
- Interrupt:
  - Set in the cycle after an accepted push.
  - Cleared by ACK.
  - Push and ACK in the same cycle: the set wins.
  - If ACK arrives while level is still >0 after any pop, the raise is re-asserted one cycle later. Level-sensitive notification guarantees no lost reports.
- Reset: FIFO empty, pointers 0, overflow 0, BUS_INTERRUPT_RAISE 0, drive enable 0 (BUS_DATA = Z), output register 8'h00. Reset mid-burst discards all stored reports.

Optional Feature:
IO_REPORT_OVERWRITE_EN
- Defined: a push when full discards the oldest report (read pointer +1) and stores the new one. Level stays DEPTH and overflow is set.
- Undefined: the new report is dropped, as described above.

Decomposition:
- Shared package: register offsets (OFF_STATUS=0, OFF_COUNT=1, OFF_HEAD=2), STATUS bit positions (ST_EMPTY=0, ST_FULL=1, ST_OVF=2), OVF_CLR_BIT=7.
- One sub-module: io_report_fifo, a synchronous FIFO with width NBYTES*8 and depth DEPTH. It exposes push, pop, head, level, full and empty. The wrapper owns the bus decode, overflow flag, interrupt and output register.

Test Plan:
- Reset, then read A0, A1, A2 → BUS_DATA = 8'h01, 8'h00, 8'h00 one cycle after each address. BUS_DATA = Z when idle. RAISE = 0.
- Push 32'hDDCCBBAA → RAISE = 1 next cycle. A1 = 8'h01; A2..A5 = AA, BB, CC, DD. Write A1 → A0 = 8'h01. ACK → RAISE = 0.
- Push 9 reports, DEPTH = 8 → A0 = 8'h06, A1 = 8'h08, head = first report. Write A0 = 8'h80 → A0 = 8'h02.
- Full FIFO, then push and pop in the same cycle → A1 stays 8'h08, overflow stays 0, head = second report. Drain 8 pops → empty. Further pops → level stays 0.
- ACK in the same cycle as a push → RAISE stays 1. Two reports queued, one ACK and one pop → RAISE re-asserts one cycle later.
- With IO_REPORT_OVERWRITE_EN, push 9 reports → head = report 2, level 8, overflow 1.

Source files
------------

// File: rtl/io_report_fifo_port_pkg.sv
// Shared register map and STATUS bit layout for the report FIFO port.
package io_report_fifo_port_pkg;

    localparam logic [7:0] OFF_STATUS = 8'd0;
    localparam logic [7:0] OFF_COUNT  = 8'd1;
    localparam logic [7:0] OFF_HEAD   = 8'd2;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVF      = 2;
    localparam int OVF_CLR_BIT = 7;

    function automatic logic [7:0] status_byte(input logic empty, input logic full,
                                               input logic ovf);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        s[ST_OVF]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/io_report_fifo.sv
// Synchronous report FIFO: push/pop with head, level, full and empty.
// A pop on a full FIFO frees a slot, so a same-cycle push is still accepted.
module io_report_fifo
    import io_report_fifo_port_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; the wrapper masks the head while empty.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/io_report_fifo_port.sv
// Bus-mapped report FIFO port: STATUS/COUNT/HEAD window, overflow flag, interrupt.
// IO_REPORT_OVERWRITE_EN: a push while full evicts the oldest report instead of dropping.
module io_report_fifo_port
    import io_report_fifo_port_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hA0,
    parameter int         NBYTES    = 4,
    parameter int         DEPTH     = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    inout  wire  [7:0]            BUS_DATA,
    input  logic [7:0]            BUS_ADDR,
    input  logic                  BUS_WE,
    input  logic                  REPORT_VALID,
    input  logic [NBYTES*8-1:0]   REPORT_DATA,
    output logic                  BUS_INTERRUPT_RAISE,
    input  logic                  BUS_INTERRUPT_ACK
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [7:0] LAST_OFF = 8'(NBYTES + 1);

    logic [7:0]          w_off;
    logic                w_hit;
    logic                w_rd;
    logic                w_wr;
    logic                w_bus_pop;
    logic                w_fifo_pop;
    logic                w_push_ok;
    logic                w_ovf_set;
    logic                w_ovf_clr;
    logic [7:0]          w_rd_data;
    logic [NBYTES*8-1:0] w_head;
    logic [AW:0]         w_level;
    logic                w_full;
    logic                w_empty;

    logic [7:0]          r_dout;
    logic                r_drive;
    logic                r_ovf;
    logic                r_irq;
    logic                r_rearm;

    assign w_off     = BUS_ADDR - BASE_ADDR;
    assign w_hit     = (BUS_ADDR >= BASE_ADDR) && (w_off <= LAST_OFF);
    assign w_rd      = w_hit && !BUS_WE;
    assign w_wr      = w_hit && BUS_WE;
    assign w_bus_pop = w_wr && (w_off == OFF_COUNT);
    assign w_ovf_clr = w_wr && (w_off == OFF_STATUS) && BUS_DATA[OVF_CLR_BIT];
    // A same-cycle CPU pop makes room, so a full push is only lost without it.
    assign w_ovf_set = REPORT_VALID && w_full && !w_bus_pop;

`ifdef IO_REPORT_OVERWRITE_EN
    assign w_fifo_pop = w_bus_pop || (REPORT_VALID && w_full);
    assign w_push_ok  = REPORT_VALID;
`else
    assign w_fifo_pop = w_bus_pop;
    assign w_push_ok  = REPORT_VALID && (!w_full || w_bus_pop);
`endif

    io_report_fifo #(
        .WIDTH (NBYTES*8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_reset (RESET),
        .i_push  (REPORT_VALID),
        .i_pop   (w_fifo_pop),
        .i_data  (REPORT_DATA),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_rd_data = 8'h00;
        if (w_off == OFF_STATUS) begin
            w_rd_data = status_byte(w_empty, w_full, r_ovf);
        end else if (w_off == OFF_COUNT) begin
            w_rd_data = 8'(w_level);
        end else if (!w_empty) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (w_off == 8'(OFF_HEAD + k)) w_rd_data = w_head[8*k +: 8];
            end
        end
    end

    assign BUS_DATA            = r_drive ? r_dout : 8'hzz;
    assign BUS_INTERRUPT_RAISE = r_irq;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dout  <= 8'h00;
            r_drive <= 1'b0;
            r_ovf   <= 1'b0;
            r_irq   <= 1'b0;
            r_rearm <= 1'b0;
        end else begin
            r_drive <= w_rd;
            if (w_rd) r_dout <= w_rd_data;

            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;

            // An ACK that leaves reports queued re-raises one cycle after clearing.
            r_rearm <= BUS_INTERRUPT_ACK && !w_push_ok;
            if (w_push_ok)                       r_irq <= 1'b1;
            else if (BUS_INTERRUPT_ACK)          r_irq <= 1'b0;
            else if (r_rearm && w_level != '0)   r_irq <= 1'b1;
        end
    end

endmodule
